// File: rtl/uart_sched_pkg.sv
// Shared state encoding, widths and helpers for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  localparam int BYTE_W      = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int GRANT_W     = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester above ptr, wrapping to 0.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GRANT_W-1:0] gnt_idx,
  output logic               hit
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    // indices above the pointer outrank the wrapped-around ones
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i] && (i > int'(ptr))) begin
        hit     = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = GRANT_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i] && (i <= int'(ptr))) begin
        hit     = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = GRANT_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte producers, with inter-frame gap,
// start-acknowledge timeout and frame statistics.
//
// state    | meaning
// ST_IDLE  | searching requesters, ready strobe on a hit
// ST_START | tx_start held, waiting for tx_busy (bounded by ACK_TIMEOUT)
// ST_SEND  | transmitter busy, waiting for it to finish
// ST_GAP   | enforced idle clocks before the next grant
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      sched_busy,
  output logic                      err_timeout,
  input  logic                      err_clear,
  output logic [FRAME_CNT_W-1:0]    frames_sent
);

  localparam int TO_W  = cnt_width(ACK_TIMEOUT);
  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GRANT_W-1:0] PTR_RST  = GRANT_W'(NUM_REQ - 1);

  sched_state_e           state_q, state_d;
  logic [GRANT_W-1:0]     ptr_q, ptr_d;
  logic [GRANT_W-1:0]     grant_id_q, grant_id_d;
  logic [BYTE_W-1:0]      tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [FRAME_CNT_W-1:0] frames_sent_q, frames_sent_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [GRANT_W-1:0]     arb_idx;
  logic                   arb_hit;
  logic [BYTE_W-1:0]      sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .hit       (arb_hit)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = tx_start_q;
    err_timeout_d = err_timeout_q;
    frames_sent_d = frames_sent_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;

    // a timeout in the same cycle overrides the clear below
    if (err_clear) err_timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          tx_data_d  = sel_data;
          grant_id_d = arb_idx;
          ptr_d      = arb_idx;
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = ST_SEND;
        end else if (to_cnt_q == TO_LAST) begin
          tx_start_d    = 1'b0;
          err_timeout_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          frames_sent_d = frames_sent_q + FRAME_CNT_W'(1);
          gap_cnt_d     = '0;
          state_d       = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RST;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      frames_sent_q <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      err_timeout_q <= err_timeout_d;
      frames_sent_q <= frames_sent_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  // no handshake may complete while reset is held, even with IDLE decoded
  assign req_ready   = ((state_q == ST_IDLE) && resetb) ? arb_gnt : '0;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign sched_busy  = (state_q != ST_IDLE);
  assign err_timeout = err_timeout_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboarded bench for uart_tx_sched: expected frames queued by stimulus,
// checked by a monitor on every tx_start rising edge.
module tb_uart_tx_sched;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  grant_id;
  logic        sched_busy;
  logic        err_timeout;
  logic        err_clear = 1'b0;
  logic [15:0] frames_sent;

  int          n_checks = 0;
  int          n_err = 0;
  logic [10:0] exp_q[$];
  logic        xm_ack = 1'b1;
  int          busy_len = 100;

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(16), .ACK_TIMEOUT(1024)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout),
    .err_clear   (err_clear),
    .frames_sent (frames_sent)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: acknowledges a start by going busy for busy_len clocks.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (xm_ack && tx_start && resetb) begin
        tx_busy = 1'b1;
        for (int i = 0; i < busy_len && resetb; i++) @(negedge clock);
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every new start request must match the head of the scoreboard.
  initial begin
    logic       start_prev;
    logic [10:0] e;
    start_prev = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (tx_start && !start_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL frame_unexpected: got data 0x%0h grant %0d, expected no frame", tx_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", {24'd0, tx_data}, {24'd0, e[7:0]});
          check("frame_grant", {29'd0, grant_id}, {29'd0, e[10:8]});
        end
      end
      start_prev = tx_start;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // Producer: present a byte, hold it until accepted, then withdraw.
  task automatic hold_byte(input int idx, input logic [7:0] d);
    int n;
    @(negedge clock);
    req_data[idx*8 +: 8] = d;
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 4000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!req_ready[idx]) check("ready_wait_expired", 32'(idx), 32'hFFFF_FFFF);
    @(negedge clock);
    req_valid[idx] = 1'b0;
    #1;
  endtask

  task automatic wait_busy(input logic level);
    int n;
    n = 0;
    while (tx_busy !== level && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (tx_busy !== level) check("tx_busy_wait_expired", {31'd0, tx_busy}, {31'd0, level});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sched_busy && n < 4000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sched_busy) check("idle_wait_expired", {31'd0, sched_busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_grant_id", {29'd0, grant_id}, 32'd0);
    check("rst_sched_busy", {31'd0, sched_busy}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    check("rst_frames_sent", {16'd0, frames_sent}, 32'd0);
    @(negedge clock);
    resetb = 1'b1;
    #1;

    // single byte, latency and gap
    exp_q.push_back({3'd0, 8'd15});
    @(negedge clock);
    req_data[7:0] = 8'd15;
    req_valid[0] = 1'b1;
    #1;
    check("t1_ready_onehot", {28'd0, req_ready}, 32'h1);
    @(negedge clock);
    req_valid[0] = 1'b0;
    #1;
    check("t1_start_latency", {31'd0, tx_start}, 32'd1);
    wait_busy(1'b1);
    wait_busy(1'b0);
    n = 0;
    while (sched_busy && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("t1_busyfall_to_idle", 32'(n), 32'd17);
    check("t1_frames", {16'd0, frames_sent}, 32'd1);

    // full rotation, then refill starting again from 0
    busy_len = 20;
    pulse_reset();
    exp_q.push_back({3'd0, 8'd10});
    exp_q.push_back({3'd1, 8'd54});
    exp_q.push_back({3'd2, 8'd25});
    exp_q.push_back({3'd3, 8'd69});
    fork
      hold_byte(0, 8'd10);
      hold_byte(1, 8'd54);
      hold_byte(2, 8'd25);
      hold_byte(3, 8'd69);
    join
    wait_idle();
    check("t2_frames_round", {16'd0, frames_sent}, 32'd4);
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd2, 8'hA2});
    fork
      hold_byte(0, 8'hA0);
      hold_byte(2, 8'hA2);
    join
    wait_idle();
    check("t2_frames_refill", {16'd0, frames_sent}, 32'd6);

    // skip idle requester 1; next grant exactly GAP+1 after busy falls
    exp_q.push_back({3'd0, 8'h30});
    exp_q.push_back({3'd2, 8'h32});
    hold_byte(0, 8'h30);
    wait_busy(1'b1);
    @(negedge clock);
    req_data[23:16] = 8'h32;
    req_valid[2] = 1'b1;
    #1;
    wait_busy(1'b0);
    n = 0;
    while (!req_ready[2] && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("t3_busyfall_to_ready", 32'(n), 32'd17);
    @(negedge clock);
    req_valid[2] = 1'b0;
    #1;
    wait_idle();
    check("t3_frames", {16'd0, frames_sent}, 32'd8);

    // acknowledge timeout, clear, then a normal frame
    xm_ack = 1'b0;
    exp_q.push_back({3'd1, 8'd5});
    hold_byte(1, 8'd5);
    n = 0;
    while (tx_start && n < 3000) begin
      n++;
      @(negedge clock);
      #1;
    end
    check("t4_start_len", 32'(n), 32'd1024);
    check("t4_err_set", {31'd0, err_timeout}, 32'd1);
    check("t4_frames_kept", {16'd0, frames_sent}, 32'd8);
    xm_ack = 1'b1;
    @(negedge clock);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    #1;
    check("t4_err_cleared", {31'd0, err_timeout}, 32'd0);
    exp_q.push_back({3'd2, 8'd77});
    hold_byte(2, 8'd77);
    wait_idle();
    check("t4_frames_after", {16'd0, frames_sent}, 32'd9);

    // asynchronous reset during SEND
    busy_len = 100;
    exp_q.push_back({3'd1, 8'd43});
    hold_byte(1, 8'd43);
    wait_busy(1'b1);
    repeat (5) @(negedge clock);
    #1;
    check("t5_in_send", {31'd0, sched_busy}, 32'd1);
    exp_q.push_back({3'd0, 8'd22});
    exp_q.push_back({3'd3, 8'd99});
    fork
      hold_byte(0, 8'd22);
      hold_byte(3, 8'd99);
      begin
        @(negedge clock);
        #1;
        resetb = 1'b0;
        #1;
        check("t5_rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("t5_rst_grant_id", {29'd0, grant_id}, 32'd0);
        check("t5_rst_sched_busy", {31'd0, sched_busy}, 32'd0);
        check("t5_rst_frames", {16'd0, frames_sent}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
      end
    join
    wait_idle();
    check("t5_frames", {16'd0, frames_sent}, 32'd2);

    // frame counter wrap
    @(negedge clock);
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clock);
    release dut.frames_sent_q;
    #1;
    exp_q.push_back({3'd0, 8'd2});
    hold_byte(0, 8'd2);
    wait_idle();
    check("t6_frames_wrap", {16'd0, frames_sent}, 32'd0);

    // clear coincident with a timeout: set wins
    xm_ack = 1'b0;
    exp_q.push_back({3'd1, 8'h66});
    hold_byte(1, 8'h66);
    n = 0;
    while (tx_start && n < 3000) begin
      n++;
      if (n == 1024) err_clear = 1'b1;
      @(negedge clock);
      #1;
    end
    err_clear = 1'b0;
    check("t6_start_len", 32'(n), 32'd1024);
    check("t6_err_set_wins", {31'd0, err_timeout}, 32'd1);
    check("t6_frames_kept", {16'd0, frames_sent}, 32'd0);
    repeat (2) @(negedge clock);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
